led_seg_scanner_pwm: RTL and testbench

Parametrised successor to the 8-digit seven-segment scanner. Time-multiplexes NUM_DIGITS hex digits onto a shared segment bus, with per-digit enable, decimal point and blink, global PWM brightness, and selectable output polarity. All timing derives from one system clock via an internal prescaler; no divided clock input is needed. Sits in the top level between game logic (scores, countdown) and board pins seg_data/seg_sel.

---
 rtl/led_seg_scanner_pwm.sv | 200 ++++++++++++++++++++
 tb/tb_led_seg_scanner_pwm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_seg_scanner_pwm.sv
// ----------------------------------------------------------------------------
// led_seg_scanner_pwm
//
// Time-multiplexes NUM_DIGITS hex digits onto a shared seven-segment bus.
// Each digit owns one slot of SCAN_DIV clocks.  Within a slot the digit is lit
// for the first ((brightness+1)*SCAN_DIV)>>PWM_BITS clocks, which gives a
// global PWM dimming control.  Digits can be individually disabled, carry a
// decimal point, and blink with a half-period of BLINK_FRAMES full frames.
//
// Per-digit inputs and brightness are captured into a shadow register at the
// start of each slot, so input changes in the middle of a slot never tear the
// displayed value.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   digits      hex value of digit i at [4i+3:4i]
//   digit_en    1 = digit i displayed
//   dp          decimal point of digit i
//   blink_en    1 = digit i blinks
//   brightness  0 = dimmest, all-ones = whole slot lit
//   seg_data    {dp,g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   seg_sel     one-hot digit select, polarity set by SEL_ACTIVE_LOW
//   frame_tick  one-cycle pulse when the scan wraps back to digit 0
// ----------------------------------------------------------------------------
module led_seg_scanner_pwm #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 500,
    parameter int PWM_BITS       = 3,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     blink_en,
    input  logic [PWM_BITS-1:0]       brightness,
    output logic [7:0]                seg_data,
    output logic [NUM_DIGITS-1:0]     seg_sel,
    output logic                      frame_tick
);

    localparam int PC_W   = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Wide enough that (brightness+1)*SCAN_DIV can never overflow.
    localparam int PROD_W = PWM_BITS + 34;

    localparam logic [PC_W-1:0]       PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]       FC_LAST  = FC_W'(BLINK_FRAMES - 1);
    localparam logic [7:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF  = (SEL_ACTIVE_LOW != 0) ?
                                                 {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // Hex to segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan state
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FC_W-1:0]       fc_q, fc_d;
    logic                  bp_q, bp_d;

    // Slot shadow
    logic [3:0]            sh_digit_q, sh_digit_d;
    logic                  sh_dp_q, sh_dp_d;
    logic                  sh_en_q, sh_en_d;
    logic                  sh_blink_q, sh_blink_d;
    logic [PWM_BITS-1:0]   sh_bright_q, sh_bright_d;

    // Output registers
    logic [7:0]            seg_data_q, seg_data_d;
    logic [NUM_DIGITS-1:0] seg_sel_q, seg_sel_d;
    logic                  frame_tick_q, frame_tick_d;

    // Combinational helpers
    logic                  slot_end;
    logic                  frame_end;
    logic [PROD_W-1:0]     on_prod;
    logic [PROD_W-1:0]     on_lim;
    logic                  on_win;
    logic                  lit;
    logic [7:0]            data_raw;
    logic [NUM_DIGITS-1:0] sel_raw;

    always_comb begin
        slot_end  = (pc_q == PC_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);

        pc_d  = slot_end ? '0 : pc_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end

        // Blink phase flips once every BLINK_FRAMES full frames.
        fc_d = fc_q;
        bp_d = bp_q;
        if (frame_end) begin
            if (fc_q == FC_LAST) begin
                fc_d = '0;
                bp_d = ~bp_q;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end

        // Capture the settings of the digit about to be shown (idx_d).
        sh_digit_d  = sh_digit_q;
        sh_dp_d     = sh_dp_q;
        sh_en_d     = sh_en_q;
        sh_blink_d  = sh_blink_q;
        sh_bright_d = sh_bright_q;
        if (slot_end) begin
            sh_digit_d  = digits[{idx_d, 2'b00} +: 4];
            sh_dp_d     = dp[idx_d];
            sh_en_d     = digit_en[idx_d];
            sh_blink_d  = blink_en[idx_d];
            sh_bright_d = brightness;
        end

        // PWM on-window: all-ones brightness yields exactly SCAN_DIV.
        on_prod = (PROD_W'(sh_bright_q) + PROD_W'(1)) * PROD_W'(SCAN_DIV);
        on_lim  = on_prod >> PWM_BITS;
        on_win  = (PROD_W'(pc_q) < on_lim);

        lit = on_win && sh_en_q && !(sh_blink_q && bp_q);

        data_raw = 8'h00;
        sel_raw  = '0;
        if (lit) begin
            data_raw       = {sh_dp_q, hex_to_seg(sh_digit_q)};
            sel_raw[idx_q] = 1'b1;
        end

        seg_data_d   = (SEG_ACTIVE_LOW != 0) ? ~data_raw : data_raw;
        seg_sel_d    = (SEL_ACTIVE_LOW != 0) ? ~sel_raw  : sel_raw;
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= '0;
            idx_q        <= '0;
            fc_q         <= '0;
            bp_q         <= 1'b0;
            sh_digit_q   <= '0;
            sh_dp_q      <= 1'b0;
            sh_en_q      <= 1'b0;
            sh_blink_q   <= 1'b0;
            sh_bright_q  <= '0;
            seg_data_q   <= SEG_OFF;
            seg_sel_q    <= SEL_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            fc_q         <= fc_d;
            bp_q         <= bp_d;
            sh_digit_q   <= sh_digit_d;
            sh_dp_q      <= sh_dp_d;
            sh_en_q      <= sh_en_d;
            sh_blink_q   <= sh_blink_d;
            sh_bright_q  <= sh_bright_d;
            seg_data_q   <= seg_data_d;
            seg_sel_q    <= seg_sel_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_data   = seg_data_q;
    assign seg_sel    = seg_sel_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_seg_scanner_pwm.sv
// ----------------------------------------------------------------------------
// tb_led_seg_scanner_pwm
//
// Bench for led_seg_scanner_pwm with N=4, SCAN_DIV=8, PWM_BITS=2,
// BLINK_FRAMES=2, active-low select, active-high segments.  A reference model
// derives expected pins from the cycle count since reset; expectations are
// queued at each rising edge and compared on the following falling edge.
// ----------------------------------------------------------------------------
module tb_led_seg_scanner_pwm;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int PB = 2;
    localparam int BF = 2;
    localparam int FRAME = N * SD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4*N-1:0] digits;
    logic [N-1:0]  digit_en;
    logic [N-1:0]  dp;
    logic [N-1:0]  blink_en;
    logic [PB-1:0] brightness;
    logic [7:0]    seg_data;
    logic [N-1:0]  seg_sel;
    logic          frame_tick;

    int vectors     = 0;
    int miscompares = 0;
    int k = 0;   // falling edges observed since the last reset release
    int c = 0;   // model: scan cycles since the last reset release

    logic [12:0] sbq[$];

    logic [3:0]    m_dig   = '0;
    logic          m_en    = 1'b0;
    logic          m_dp    = 1'b0;
    logic          m_blink = 1'b0;
    logic [PB-1:0] m_b     = '0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    led_seg_scanner_pwm #(
        .NUM_DIGITS    (N),
        .SCAN_DIV      (SD),
        .PWM_BITS      (PB),
        .BLINK_FRAMES  (BF),
        .SEG_ACTIVE_LOW(0),
        .SEL_ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits    (digits),
        .digit_en  (digit_en),
        .dp        (dp),
        .blink_en  (blink_en),
        .brightness(brightness),
        .seg_data  (seg_data),
        .seg_sel   (seg_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h (k=%0d)", tag, act, exp, k);
        end
    endtask

    // One clock: model predicts at the rising edge, DUT compared at the falling edge.
    task automatic step();
        logic [12:0] e;
        logic [3:0]  oh;
        logic [3:0]  sel;
        logic [7:0]  dat;
        logic        lit;
        logic        ft;
        int          pc, idx, f, thr, ni;
        @(posedge clk);
        if (!rst_n) begin
            e       = {4'hF, 8'h00, 1'b0};
            c       = 0;
            m_dig   = '0;
            m_en    = 1'b0;
            m_dp    = 1'b0;
            m_blink = 1'b0;
            m_b     = '0;
        end else begin
            pc  = c % SD;
            idx = (c / SD) % N;
            f   = c / FRAME;
            thr = ((int'(m_b) + 1) * SD) >> PB;
            lit = (pc < thr) && m_en && !(m_blink && (((f / BF) % 2) == 1));
            oh  = 4'b0001 << idx;
            sel = lit ? ~oh : 4'hF;
            dat = lit ? {m_dp, seg_tab[m_dig]} : 8'h00;
            ft  = (((c + 1) % FRAME) == 0);
            e   = {sel, dat, ft};
            if (((c + 1) % SD) == 0) begin
                ni      = ((c + 1) / SD) % N;
                m_dig   = digits[ni*4 +: 4];
                m_en    = digit_en[ni];
                m_dp    = dp[ni];
                m_blink = blink_en[ni];
                m_b     = brightness;
            end
            c++;
        end
        sbq.push_back(e);
        @(negedge clk);
        k++;
        if (sbq.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk("seg_sel", 32'(seg_sel), 32'(e[12:9]));
            chk("seg_data", 32'(seg_data), 32'(e[8:1]));
            chk("frame_tick", 32'(frame_tick), 32'(e[0]));
            chk("sel_onehot", 32'($countones(~seg_sel) <= 1), 32'd1);
        end
    endtask

    // Called at a falling edge; holds reset for three clocks.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        k = 0;
    endtask

    int cnt_b0, cnt_b1, cnt_a, cnt_z, cnt_blank, cnt_bad;
    int lit0 [5];
    int lit1 [5];

    initial begin
        rst_n      = 1'b0;
        digits     = 16'h3210;
        digit_en   = 4'hF;
        dp         = 4'h0;
        blink_en   = 4'h0;
        brightness = 2'd3;
        cnt_b0 = 0; cnt_b1 = 0; cnt_a = 0; cnt_z = 0; cnt_blank = 0; cnt_bad = 0;
        for (int i = 0; i < 5; i++) begin
            lit0[i] = 0;
            lit1[i] = 0;
        end

        @(negedge clk);
        chk("rst_sel", 32'(seg_sel), 32'hF);
        chk("rst_data", 32'(seg_data), 32'h00);
        chk("rst_ft", 32'(frame_tick), 32'd0);
        do_reset();

        // Full brightness scan, then dimming, then enable/dp pattern.
        for (int i = 0; i < 160; i++) begin
            step();
            if (k == 4)  chk("slot0_blank", 32'(seg_sel), 32'hF);
            if (k == 9)  begin chk("d1_sel", 32'(seg_sel), 32'hD); chk("d1_data", 32'(seg_data), 32'h06); end
            if (k == 17) begin chk("d2_sel", 32'(seg_sel), 32'hB); chk("d2_data", 32'(seg_data), 32'h5B); end
            if (k == 25) begin chk("d3_sel", 32'(seg_sel), 32'h7); chk("d3_data", 32'(seg_data), 32'h4F); end
            if (k == 32) chk("ftick_32", 32'(frame_tick), 32'd1);
            if (k == 33) begin chk("d0_sel", 32'(seg_sel), 32'hE); chk("d0_data", 32'(seg_data), 32'h3F); end
            if (k == 64) chk("ftick_64", 32'(frame_tick), 32'd1);
            if (k >= 65 && k <= 96 && seg_sel != 4'hF)  cnt_b0++;
            if (k >= 97 && k <= 128 && seg_sel != 4'hF) cnt_b1++;
            if (k >= 129 && k <= 160) begin
                if (seg_sel == 4'hE && seg_data == 8'hFF)      cnt_a++;
                else if (seg_sel == 4'hB && seg_data == 8'h3F) cnt_z++;
                else if (seg_sel == 4'hF)                      cnt_blank++;
                else                                           cnt_bad++;
            end
            if (k == 63) brightness = 2'd0;
            if (k == 95) brightness = 2'd1;
            if (k == 127) begin
                brightness = 2'd3;
                digit_en   = 4'b0101;
                dp         = 4'b0001;
                digits     = 16'h00F8;
            end
        end
        chk("b0_lit_cycles", 32'(cnt_b0), 32'd8);
        chk("b1_lit_cycles", 32'(cnt_b1), 32'd16);
        chk("en_d0_dp_cycles", 32'(cnt_a), 32'd8);
        chk("en_d2_cycles", 32'(cnt_z), 32'd8);
        chk("en_blank_cycles", 32'(cnt_blank), 32'd16);
        chk("en_other_cycles", 32'(cnt_bad), 32'd0);

        // Blink on digit 1, then a mid-slot digit change, then async reset.
        digits   = 16'h3210;
        digit_en = 4'hF;
        dp       = 4'h0;
        blink_en = 4'b0010;
        do_reset();
        for (int i = 0; i < 213; i++) begin
            step();
            if (k <= 160) begin
                if (seg_sel == 4'hD) lit1[(k - 1) / FRAME]++;
                if (seg_sel == 4'hE) lit0[(k - 1) / FRAME]++;
            end
            if (k == 160) blink_en = 4'h0;
            if (k == 172) begin
                chk("pre_change", 32'(seg_data), 32'h06);
                digits = 16'h3270;
            end
            if (k == 173) chk("mid_hold_a", 32'(seg_data), 32'h06);
            if (k == 176) chk("mid_hold_b", 32'(seg_data), 32'h06);
            if (k == 201) chk("new_val_a", 32'(seg_data), 32'h07);
            if (k == 208) chk("new_val_b", 32'(seg_data), 32'h07);
        end
        chk("blink_f0", 32'(lit1[0]), 32'd8);
        chk("blink_f1", 32'(lit1[1]), 32'd8);
        chk("blink_f2", 32'(lit1[2]), 32'd0);
        chk("blink_f3", 32'(lit1[3]), 32'd0);
        chk("blink_f4", 32'(lit1[4]), 32'd8);
        chk("noblink_d0_f2", 32'(lit0[2]), 32'd8);

        // Scanner now sits at slot 2, pc=5; output shows digit 2 lit.
        chk("pre_rst_sel", 32'(seg_sel), 32'hB);
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", 32'(seg_sel), 32'hF);
        chk("async_rst_data", 32'(seg_data), 32'h00);
        chk("async_rst_ft", 32'(frame_tick), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (k == 1) chk("post_rst_blank_a", 32'(seg_sel), 32'hF);
            if (k == 8) chk("post_rst_blank_b", 32'(seg_sel), 32'hF);
            if (k == 9) begin
                chk("post_rst_d1_sel", 32'(seg_sel), 32'hD);
                chk("post_rst_d1_data", 32'(seg_data), 32'h07);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
